// File: rtl/latch_change_fifo.sv
// Change-detecting sampler feeding a first-word-fall-through FIFO for the latch stage output.
// Optional drop counter enabled by defining LCF_DROP_CNT_EN.
module latch_change_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
`ifdef LCF_DROP_CNT_EN
    ,parameter int CNT_W = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   sample_en,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
`ifdef LCF_DROP_CNT_EN
    ,output logic [CNT_W-1:0]      drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] last_val_reg;
    logic             seen_reg;
    logic             empty;
    logic             push_req;
    logic             push;
    logic             pop;

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_reg[AW-1:0]];

    // Full is judged on the registered state, so a same-edge pop never frees room for a push.
    assign push_req = sample_en && (!seen_reg || (data_in != last_val_reg));
    assign push     = push_req && !full;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val_reg <= '0;
            seen_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            if (sample_en) begin
                last_val_reg <= data_in;
                seen_reg     <= 1'b1;
            end
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= data_in;
    end

`ifdef LCF_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_reg <= '0;
        else if (push_req && full && (drop_cnt_reg != {CNT_W{1'b1}}))
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_latch_change_fifo.sv
// Table-driven bench for latch_change_fifo with a queue scoreboard for the FIFO data path.
module tb_latch_change_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             sample_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic [2:0]       level;
`ifdef LCF_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    latch_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sample_en (sample_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .level     (level)
`ifdef LCF_DROP_CNT_EN
        ,.drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         se;
        logic [3:0] d;
        bit         rdy;
        int         lvl;
        int         drp;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] m_last;
    bit               m_seen;
    bit               m_start_full;
    logic [WIDTH-1:0] exp_word;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        tbl = '{
            '{1, 1, 4'd4,  0, 1, 0},  // first sample after reset
            '{0, 1, 4'd4,  0, 1, 0},
            '{0, 1, 4'd4,  0, 1, 0},
            '{1, 1, 4'd1,  0, 1, 0},  // change sequence
            '{0, 1, 4'd9,  0, 2, 0},
            '{0, 1, 4'd9,  0, 2, 0},
            '{0, 1, 4'd3,  0, 3, 0},
            '{0, 1, 4'd13, 0, 4, 0},
            '{0, 1, 4'd5,  0, 4, 1},  // overflow drop
            '{0, 0, 4'd5,  1, 3, 1},  // pop yields 1
            '{0, 0, 4'd5,  1, 2, 1},
            '{0, 1, 4'd2,  1, 2, 1},  // simultaneous push and pop
            '{0, 0, 4'd6,  0, 2, 1},  // gating
            '{0, 0, 4'd7,  0, 2, 1},
            '{0, 0, 4'd6,  0, 2, 1},
            '{0, 1, 4'd2,  0, 2, 1},  // repeated value, no push
            '{0, 1, 4'd7,  1, 2, 1},
            '{0, 1, 4'd8,  0, 3, 1},
            '{1, 1, 4'd8,  0, 1, 0},  // mid-stream reset, same value pushed again
            '{0, 1, 4'd1,  0, 2, 0},
            '{0, 1, 4'd2,  0, 3, 0},
            '{0, 1, 4'd3,  0, 4, 0},
            '{0, 1, 4'd4,  1, 3, 1},  // drop while full even with a pop
            '{0, 0, 4'd0,  1, 2, 1},
            '{0, 0, 4'd0,  1, 1, 1},
            '{0, 0, 4'd0,  1, 0, 1},
            '{0, 0, 4'd0,  1, 0, 1}   // pop request on empty FIFO
        };

        rst       = 1'b1;
        sample_en = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        m_last    = '0;
        m_seen    = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (tbl[i].rst) begin
                rst = 1'b1;
                #1;
                chk("rst_level", i, int'(level), 0);
                chk("rst_valid", i, int'(out_valid), 0);
                chk("rst_full", i, int'(full), 0);
`ifdef LCF_DROP_CNT_EN
                chk("rst_drop", i, int'(drop_cnt), 0);
`endif
                rst = 1'b0;
                sb.delete();
                m_seen = 1'b0;
                m_last = '0;
            end

            sample_en = tbl[i].se;
            data_in   = tbl[i].d;
            out_ready = tbl[i].rdy;
            #1;

            m_start_full = (sb.size() == DEPTH);
            chk("pre_valid", i, int'(out_valid), int'(sb.size() != 0));
            if (out_ready && sb.size() != 0) begin
                exp_word = sb.pop_front();
                chk("pop_data", i, int'(out_data), int'(exp_word));
            end
            if (sample_en && (!m_seen || data_in != m_last) && !m_start_full)
                sb.push_back(data_in);
            if (sample_en) begin
                m_seen = 1'b1;
                m_last = data_in;
            end

            @(posedge clk);
            #1;
            chk("level", i, int'(level), tbl[i].lvl);
            chk("full", i, int'(full), int'(tbl[i].lvl == DEPTH));
            chk("valid", i, int'(out_valid), int'(tbl[i].lvl != 0));
            if (sb.size() != 0)
                chk("head", i, int'(out_data), int'(sb[0]));
`ifdef LCF_DROP_CNT_EN
            chk("drop_cnt", i, int'(drop_cnt), tbl[i].drp);
`endif
            $display("vec %0d: se=%0d d=%0d rdy=%0d -> level=%0d valid=%0d full=%0d head=%0d",
                     i, sample_en, data_in, out_ready, level, out_valid, full, out_data);
        end

        // Head must stay stable while stalled: refill with two values and hold ready low.
        @(negedge clk);
        sample_en = 1'b1;
        out_ready = 1'b0;
        data_in   = 4'd11;
        @(negedge clk);
        data_in   = 4'd12;
        @(negedge clk);
        sample_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall_head", k, int'(out_data), 11);
            chk("stall_level", k, int'(level), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/latch_change_fifo.md
# latch_change_fifo

Downstream consumer of the Johnson-phased latch stage. Samples the latched data word on qualified clock edges, detects value changes and queues each new value in a small first-word-fall-through FIFO, so later stages take changes through a valid/ready handshake instead of polling the latch. Changes that arrive while the FIFO is full are dropped, never overwritten.

## Interface
- WIDTH, 4: data width; matches the latch stage's data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the drop counter; present only with the configuration macro.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- data_in  input  WIDTH  latched data word from the upstream latch stage.
- sample_en  input  1  qualifies data_in on the current edge; driven high during the latch-transparent phase.
- out_data  output  WIDTH  FIFO head word; valid only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head word when out_valid=1.
- full  output  1  FIFO holds DEPTH entries.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- drop_cnt  output  CNT_W  saturating count of dropped changes; exists only with LCF_DROP_CNT_EN.

## Operation
- Change detector registers:
  - last_val (WIDTH bits), reset value 0.
  - seen (1 bit), reset value 0.
- On an edge with sample_en=1, the detector raises a push request when seen=0 or data_in != last_val.
  - The first qualified sample after reset always produces a push.
  - On the same edge, last_val takes data_in and seen is set to 1, whether the push is accepted or dropped.
- With sample_en=0, the detector holds and raises no push request.
- FIFO:
  - Circular memory of DEPTH words.
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Both pointers wrap naturally modulo 2*DEPTH.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - level is wr_ptr minus rd_ptr, computed modulo 2*DEPTH.
- Push:
  - Writes data_in at wr_ptr and increments wr_ptr, but only if full=0 at the start of the cycle.
  - A push request while full=1 is dropped, even if a pop happens on the same edge.
- Pop: occurs when out_valid and out_ready are both 1; increments rd_ptr.
- Push and pop on the same edge with 0 < level < DEPTH: both take effect and level is unchanged.
- Push into an empty FIFO: there is no pop that cycle, because out_valid=0.
- out_data is driven combinationally as mem[rd_ptr low bits] (first-word fall-through).
  - Holds its value while out_valid=1 and out_ready=0.
  - Don't-care while out_valid=0.
- Reset values:
  - out_valid=0, full=0, level=0, drop_cnt=0.
  - Both pointers 0, last_val=0, seen=0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all queued entries immediately, with no clock required.

## Timing
- Latency: a change sampled at edge N gives out_valid=1 and out_data = that value after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle.
- full, level and out_valid are decoded from the registered pointers and change only on clock edges or reset.
- Reset release is synchronous in effect: the first qualified edge after rst falls is treated as the first sample.

## Configuration
- LCF_DROP_CNT_EN defined:
  - Adds the drop_cnt port and a CNT_W-bit counter.
  - The counter increments by 1 on every dropped push request.
  - It saturates at all-ones and clears only on rst.
- LCF_DROP_CNT_EN undefined:
  - Neither the port nor the counter exists.
  - Drops are silent; all other behaviour is identical.

## Test plan
- First sample after reset:
  - Stimulus: rst pulse, then data_in=4, sample_en=1 for 3 edges, out_ready=0.
  - Response: exactly one entry; level=1, out_data=4.
- Change sequence:
  - Stimulus: data_in = 1, 9, 9, 3, 13 on successive qualified edges, out_ready=0.
  - Response: level=4, full=1; pops yield 1, 9, 3, 13 in order.
- Overflow:
  - Stimulus: DEPTH=4 FIFO full of 1, 9, 3, 13; then data_in=5 sampled, followed by a pop.
  - Response: 5 dropped; the pop yields 1; drop_cnt=1 with the macro defined.
- Simultaneous push and pop:
  - Stimulus: level=2, out_ready=1, new value 2 sampled on the same edge.
  - Response: level stays 2; 2 appears after the older entries.
- Gating:
  - Stimulus: sample_en=0 while data_in toggles 6, 7, 6.
  - Response: no push; level unchanged.
- Reset mid-stream:
  - Stimulus: rst asserted between edges with level=3.
  - Response: immediately out_valid=0, level=0, full=0; the next qualified sample is pushed even if it equals the pre-reset last_val.
